// File: rtl/ping_pong_buffer_if.sv
// Producer/consumer handshake bundle for the ping-pong frame buffer.
// The slave modport is the buffer side; the master modport is the traffic side.
interface ping_pong_buffer_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             wr_last;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic             rd_last;
    logic [1:0]       bank_full;

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  wr_last,
        input  rd_ready,
        output wr_ready,
        output rd_valid,
        output rd_data,
        output rd_last,
        output bank_full
    );

    modport master (
        output wr_valid,
        output wr_data,
        output wr_last,
        output rd_ready,
        input  wr_ready,
        input  rd_valid,
        input  rd_data,
        input  rd_last,
        input  bank_full
    );
endinterface

// File: rtl/ping_pong_buffer.sv
// Two-bank frame buffer: the writer fills an EMPTY bank while the reader drains a FULL one.
// Ownership swaps on seal (writer) or on the final read (reader), each a single-edge update.
module ping_pong_buffer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    ping_pong_buffer_if.slave bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(2 * DEPTH);
    localparam logic [CW-1:0] LastIdx = CW'(DEPTH - 1);
    localparam logic [AW-1:0] BankOfs = AW'(DEPTH);

    typedef enum logic {StEmpty, StFull} bank_state_e;

    bank_state_e      state_q [2];
    logic [CW-1:0]    len_q   [2];
    logic             wbank_q;
    logic             rbank_q;
    logic [CW-1:0]    wcnt_q;
    logic [CW-1:0]    rcnt_q;
    logic [WIDTH-1:0] mem_q   [2*DEPTH];

    logic          wr_acc;
    logic          wr_seal;
    logic          rd_acc;
    logic          rd_end;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;

    // Writes only ever land in an EMPTY bank and reads only come from a FULL one,
    // so a concurrent seal and drain always touch different banks.
    assign bus.wr_ready  = (state_q[wbank_q] == StEmpty);
    assign bus.rd_valid  = (state_q[rbank_q] == StFull);
    assign bus.rd_last   = bus.rd_valid && (rcnt_q == len_q[rbank_q] - CW'(1));
    assign bus.bank_full = {state_q[1] == StFull, state_q[0] == StFull};

    assign wr_acc  = bus.wr_valid && bus.wr_ready;
    assign wr_seal = bus.wr_last || (wcnt_q == LastIdx);
    assign rd_acc  = bus.rd_valid && bus.rd_ready;
    assign rd_end  = rd_acc && bus.rd_last;

    assign waddr = wbank_q ? (BankOfs + AW'(wcnt_q)) : AW'(wcnt_q);
    assign raddr = rbank_q ? (BankOfs + AW'(rcnt_q)) : AW'(rcnt_q);

    assign bus.rd_data = bus.rd_valid ? mem_q[raddr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= StEmpty;
                len_q[i]   <= '0;
            end
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
        end else if (flush) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= StEmpty;
                len_q[i]   <= '0;
            end
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
        end else begin
            if (wr_acc) begin
                if (wr_seal) begin
                    state_q[wbank_q] <= StFull;
                    len_q[wbank_q]   <= wcnt_q + CW'(1);
                    wbank_q          <= ~wbank_q;
                    wcnt_q           <= '0;
                end else begin
                    wcnt_q <= wcnt_q + CW'(1);
                end
            end
            if (rd_acc) begin
                if (rd_end) begin
                    state_q[rbank_q] <= StEmpty;
                    rbank_q          <= ~rbank_q;
                    rcnt_q           <= '0;
                end else begin
                    rcnt_q <= rcnt_q + CW'(1);
                end
            end
        end
    end

    // Storage carries no reset; validity is tracked entirely by the bank state.
    always_ff @(posedge clk) begin
        if (wr_acc && !flush) begin
            mem_q[waddr] <= bus.wr_data;
        end
    end

endmodule

// File: tb/tb_ping_pong_buffer.sv
// Directed bench for ping_pong_buffer; read data is checked against a frame scoreboard
// filled from accepted writes.
module tb_ping_pong_buffer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    int tests = 0;
    int fails = 0;

    exp_t             exp_q  [$];
    logic [WIDTH-1:0] pend_q [$];

    ping_pong_buffer_if #(.WIDTH(WIDTH)) bus ();

    ping_pong_buffer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observe handshakes just before the edge, update the model, then step past the edge.
    task automatic tick();
        exp_t e;
        if (flush) begin
            exp_q.delete();
            pend_q.delete();
        end else begin
            if (bus.rd_valid && bus.rd_ready) begin
                tests++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL rd_unexpected: observed %0h expected none", bus.rd_data);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rd_data", 32'(bus.rd_data), 32'(e.data));
                    check("rd_last", 32'(bus.rd_last), 32'(e.last));
                end
            end
            if (bus.wr_valid && bus.wr_ready) begin
                pend_q.push_back(bus.wr_data);
                if (bus.wr_last || pend_q.size() == DEPTH) begin
                    for (int i = 0; i < pend_q.size(); i++) begin
                        e.data = pend_q[i];
                        e.last = (i == pend_q.size() - 1);
                        exp_q.push_back(e);
                    end
                    pend_q.delete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [WIDTH-1:0] d, input logic l);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        bus.wr_last  = l;
        tick();
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'd1);
        check({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
        check({tag, "_rd_data"}, 32'(bus.rd_data), 32'd0);
        check({tag, "_rd_last"}, 32'(bus.rd_last), 32'd0);
        check({tag, "_bank_full"}, 32'(bus.bank_full), 32'd0);
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.wr_last  = 1'b0;
        bus.rd_ready = 1'b0;

        // 1: reset with no clock edge yet
        #2;
        check_idle("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 2: fill bank0, then bank1, with the reader stalled
        for (int i = 0; i < 4; i++) put(8'h11 + 8'(i), 1'b0);
        check("t2_rd_valid", 32'(bus.rd_valid), 32'd1);
        check("t2_rd_data", 32'(bus.rd_data), 32'h11);
        check("t2_bank_full", 32'(bus.bank_full), 32'b01);
        check("t2_wr_ready", 32'(bus.wr_ready), 32'd1);
        for (int i = 0; i < 4; i++) put(8'h21 + 8'(i), 1'b0);
        check("t2_wr_ready_full", 32'(bus.wr_ready), 32'd0);
        check("t2_bank_full_both", 32'(bus.bank_full), 32'b11);
        // writes offered while both banks are full must be ignored
        put(8'h99, 1'b0);
        put(8'h9a, 1'b1);
        check("t2_ignored_full", 32'(bus.bank_full), 32'b11);
        check("t2_hold_data", 32'(bus.rd_data), 32'h11);
        check("t2_hold_last", 32'(bus.rd_last), 32'd0);

        // 3: drain both banks back-to-back
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("t3_wr_ready", 32'(bus.wr_ready), 32'd1);
        check("t3_bank_full", 32'(bus.bank_full), 32'b10);
        check("t3_rd_data_b1", 32'(bus.rd_data), 32'h21);
        for (int i = 0; i < 4; i++) tick();
        check("t3_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("t3_bank_full_end", 32'(bus.bank_full), 32'b00);
        bus.rd_ready = 1'b0;

        // 4: short frame sealed by wr_last
        put(8'hA0, 1'b0);
        check("t4_partial_hidden", 32'(bus.rd_valid), 32'd0);
        put(8'hA1, 1'b1);
        check("t4_bank_full", 32'(bus.bank_full), 32'b01);
        check("t4_rd_data", 32'(bus.rd_data), 32'hA0);
        bus.rd_ready = 1'b1;
        tick();
        tick();
        check("t4_rd_valid", 32'(bus.rd_valid), 32'd0);

        // 5: seal bank1 on the same edge that drains bank0
        put(8'h51, 1'b1);
        tick();
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) put(8'h31 + 8'(i), 1'b0);
        put(8'h41, 1'b0);
        put(8'h42, 1'b0);
        bus.rd_ready = 1'b1;
        tick();
        tick();
        tick();
        check("t5_pre_bank_full", 32'(bus.bank_full), 32'b01);
        check("t5_pre_rd_last", 32'(bus.rd_last), 32'd1);
        put(8'h43, 1'b1);
        check("t5_bank_full", 32'(bus.bank_full), 32'b10);
        check("t5_rd_valid", 32'(bus.rd_valid), 32'd1);
        check("t5_rd_data", 32'(bus.rd_data), 32'h41);
        tick();
        tick();
        tick();
        check("t5_rd_valid_end", 32'(bus.rd_valid), 32'd0);
        bus.rd_ready = 1'b0;

        // 6: asynchronous reset mid-drain, then flush with both banks full
        for (int i = 0; i < 4; i++) put(8'h11 + 8'(i), 1'b0);
        for (int i = 0; i < 4; i++) put(8'h21 + 8'(i), 1'b0);
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        check("t6_rd_data", 32'(bus.rd_data), 32'h12);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        pend_q.delete();
        #1;
        check_idle("t6_async");
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) put(8'h61 + 8'(i), 1'b0);
        for (int i = 0; i < 4; i++) put(8'h71 + 8'(i), 1'b0);
        check("t6_refill", 32'(bus.bank_full), 32'b11);
        flush        = 1'b1;
        bus.rd_ready = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hEE;
        tick();
        flush        = 1'b0;
        bus.rd_ready = 1'b0;
        bus.wr_valid = 1'b0;
        check_idle("t6_flush");

        // post-flush: partial frame stays hidden until sealed
        put(8'h81, 1'b0);
        put(8'h82, 1'b0);
        check("t7_partial_hidden", 32'(bus.rd_valid), 32'd0);
        check("t7_partial_ready", 32'(bus.wr_ready), 32'd1);
        put(8'h83, 1'b1);
        check("t7_bank_full", 32'(bus.bank_full), 32'b01);
        check("t7_rd_data", 32'(bus.rd_data), 32'h81);
        bus.rd_ready = 1'b1;
        tick();
        tick();
        tick();
        bus.rd_ready = 1'b0;
        check("t7_rd_valid_end", 32'(bus.rd_valid), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
